// File: rtl/io_bus_arbiter.sv
// Two-core to single-peripheral bus arbiter: per-core request FIFOs, round-robin grant,
// one outstanding peripheral transaction, read-response routing with timeout.
module io_bus_arbiter #(
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_addr_en,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic        c0_w_nrr,
  input  logic [3:0]  c0_wstrb,
  output logic [31:0] c0_rdata,
  output logic        c0_rvalid,
  input  logic        c1_addr_en,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c1_wdata,
  input  logic        c1_w_nrr,
  input  logic [3:0]  c1_wstrb,
  output logic [31:0] c1_rdata,
  output logic        c1_rvalid,
  output logic        p_req,
  input  logic        p_ack,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  output logic        p_w_nrr,
  output logic [3:0]  p_wstrb,
  input  logic [31:0] p_rdata,
  input  logic        p_rvalid,
  output logic [1:0]  ovf,
  output logic        tmo
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [31:0]   ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        w_nrr;
    logic [3:0]  wstrb;
  } ent_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  ent_t             mem [2][QDEPTH];
  ent_t [1:0]       push_ent;
  ent_t             head;
  logic [1:0][AW:0] wr_ptr;
  logic [1:0][AW:0] rd_ptr;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       full;
  logic [1:0]       empty;

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rsp_vld_p0;
  logic          rsp_tmo_p0;
  logic [31:0]   rsp_data_p0;

  assign push        = {c1_addr_en, c0_addr_en};
  assign push_ent[0] = {c0_addr, c0_wdata, c0_w_nrr, c0_wstrb};
  assign push_ent[1] = {c1_addr, c1_wdata, c1_w_nrr, c1_wstrb};
  assign pop         = {p_ack & gnt, p_ack & ~gnt} & {2{state == ISSUE}};

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      empty[n] = (wr_ptr[n] == rd_ptr[n]);
      full[n]  = (wr_ptr[n][AW] != rd_ptr[n][AW]) &&
                 (wr_ptr[n][AW-1:0] == rd_ptr[n][AW-1:0]);
    end
  end

  // A full FIFO still accepts a push when its head is popped on the same edge.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n] && (!full[n] || pop[n]))
        mem[n][wr_ptr[n][AW-1:0]] <= push_ent[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n] && (!full[n] || pop[n])) wr_ptr[n] <= wr_ptr[n] + PTR_ONE;
        if (pop[n])                          rd_ptr[n] <= rd_ptr[n] + PTR_ONE;
        if (push[n] && full[n] && !pop[n])   ovf[n]    <= 1'b1;
      end
    end
  end

  assign head    = mem[gnt][rd_ptr[gnt][AW-1:0]];
  assign p_req   = (state == ISSUE);
  assign p_addr  = head.addr;
  assign p_wdata = head.wdata;
  assign p_w_nrr = head.w_nrr;
  assign p_wstrb = head.wstrb;

  // gnt doubles as the last-grant pointer; resetting it to 1 lets core 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    cnt_nxt     = cnt;
    rsp_vld_p0  = 1'b0;
    rsp_tmo_p0  = 1'b0;
    rsp_data_p0 = p_rdata;
    unique case (state)
      IDLE: begin
        if (!empty[0] || !empty[1]) begin
          gnt_nxt   = (!empty[0] && !empty[1]) ? ~gnt : empty[0];
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (p_ack) begin
          if (head.w_nrr) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_RD;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT_RD: begin
        if (p_rvalid) begin
          rsp_vld_p0 = 1'b1;
          state_nxt  = IDLE;
        end else if (cnt == CNT_MAX) begin
          rsp_vld_p0  = 1'b1;
          rsp_tmo_p0  = 1'b1;
          rsp_data_p0 = ERR_DATA;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response stage: route the completion to the granted core only.
  always_ff @(posedge clk) begin
    if (rst) begin
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
      c0_rdata  <= '0;
      c1_rdata  <= '0;
      tmo       <= 1'b0;
    end else begin
      c0_rvalid <= rsp_vld_p0 && !gnt;
      c1_rvalid <= rsp_vld_p0 && gnt;
      if (rsp_vld_p0 && !gnt) c0_rdata <= rsp_data_p0;
      if (rsp_vld_p0 && gnt)  c1_rdata <= rsp_data_p0;
      if (rsp_tmo_p0)         tmo      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: vector table for per-cycle behaviour plus
// hand sequences for overflow, full-FIFO pop/push, timeout and mid-read reset.
module tb_io_bus_arbiter;

  localparam int QDEPTH  = 2;
  localparam int TIMEOUT = 255;
  localparam logic [31:0] WMASK = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_addr_en, c0_w_nrr, c0_rvalid;
  logic [31:0] c0_addr, c0_wdata, c0_rdata;
  logic [3:0]  c0_wstrb;
  logic        c1_addr_en, c1_w_nrr, c1_rvalid;
  logic [31:0] c1_addr, c1_wdata, c1_rdata;
  logic [3:0]  c1_wstrb;
  logic        p_req, p_ack, p_w_nrr, p_rvalid;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [3:0]  p_wstrb;
  logic [1:0]  ovf;
  logic        tmo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .c0_addr_en(c0_addr_en), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_w_nrr(c0_w_nrr),
    .c0_wstrb(c0_wstrb), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
    .c1_addr_en(c1_addr_en), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_w_nrr(c1_w_nrr),
    .c1_wstrb(c1_wstrb), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .p_req(p_req), .p_ack(p_ack), .p_addr(p_addr), .p_wdata(p_wdata), .p_w_nrr(p_w_nrr),
    .p_wstrb(p_wstrb), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .ovf(ovf), .tmo(tmo)
  );

  typedef struct {
    logic        rst;
    logic        c0e, c0w;
    logic [31:0] c0a;
    logic        c1e, c1w;
    logic [31:0] c1a;
    logic        ack, rv;
    logic [31:0] rd;
    logic        ereq, ewr;
    logic [31:0] eaddr;
    logic        erv0, erv1;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic clear_in();
    c0_addr_en = 0; c0_addr = '0; c0_wdata = '0; c0_w_nrr = 0; c0_wstrb = '0;
    c1_addr_en = 0; c1_addr = '0; c1_wdata = '0; c1_w_nrr = 0; c1_wstrb = '0;
    p_ack = 0; p_rvalid = 0; p_rdata = '0;
  endtask

  task automatic drive_req(input int n, input logic wr, input logic [31:0] a);
    if (n == 0) begin
      c0_addr_en = 1; c0_addr = a; c0_wdata = a ^ WMASK; c0_w_nrr = wr; c0_wstrb = a[15:12];
    end else begin
      c1_addr_en = 1; c1_addr = a; c1_wdata = a ^ WMASK; c1_w_nrr = wr; c1_wstrb = a[15:12];
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk); #1;
    rst = 0;
    clear_in();
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_head(input string nm, input logic wr, input logic [31:0] a);
    logic [31:0] wd;
    logic [3:0]  ws;
    wd = a ^ WMASK;
    ws = a[15:12];
    chk({nm, " p_req"},   p_req,   1);
    chk({nm, " p_addr"},  p_addr,  a);
    chk({nm, " p_w_nrr"}, p_w_nrr, wr);
    chk({nm, " p_wdata"}, p_wdata, wd);
    chk({nm, " p_wstrb"}, p_wstrb, ws);
  endtask

  task automatic do_reset();
    begin_cycle();
    rst = 1;
    @(posedge clk); #1;
    mid();
    chk("rst p_req", p_req, 0);
    chk("rst c0_rvalid", c0_rvalid, 0);
    chk("rst c1_rvalid", c1_rvalid, 0);
    chk("rst c0_rdata", c0_rdata, 0);
    chk("rst c1_rdata", c1_rdata, 0);
    chk("rst ovf", ovf, 0);
    chk("rst tmo", tmo, 0);
  endtask

  initial begin
    int          n_iss;
    int          quiet;
    logic [31:0] iss [4];

    rst = 1;
    clear_in();

    // rst, c0e,c0w,c0a, c1e,c1w,c1a, ack,rv,rd, ereq,ewr,eaddr, erv0,erv1,erd
    tbl.push_back(vec_t'{1, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 1,0,32'h1000,  0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            1,0,32'h1000,  0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,1,32'h1234,     0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         1,0,32'h1234});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{1, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 1,1,32'h2000,  1,1,32'h3000,  1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            1,1,32'h2000,  0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            1,1,32'h3000,  0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         1,0,32'h4000,  0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            1,0,32'h4000,  0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,1,32'hCAFE0001, 0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,1,32'h1111,     0,0,0,         0,1,32'hCAFE0001});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 1,1,32'h2100,  0,0,0,         1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            1,1,32'h2100,  0,0,0});
    tbl.push_back(vec_t'{0, 1,1,32'h2200,  1,1,32'h3200,  1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            1,1,32'h3200,  0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            0,0,0,         0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         1,0,0,            1,1,32'h2200,  0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,         0,0,0,         0,0,0,            0,0,0,         0,0,0});

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        begin_cycle();
        if (tbl[i].c0e) drive_req(0, tbl[i].c0w, tbl[i].c0a);
        if (tbl[i].c1e) drive_req(1, tbl[i].c1w, tbl[i].c1a);
        p_ack = tbl[i].ack; p_rvalid = tbl[i].rv; p_rdata = tbl[i].rd;
        mid();
        chk($sformatf("row%0d p_req", i), p_req, tbl[i].ereq);
        if (tbl[i].ereq) check_head($sformatf("row%0d", i), tbl[i].ewr, tbl[i].eaddr);
        chk($sformatf("row%0d c0_rvalid", i), c0_rvalid, tbl[i].erv0);
        chk($sformatf("row%0d c1_rvalid", i), c1_rvalid, tbl[i].erv1);
        if (tbl[i].erv0) chk($sformatf("row%0d c0_rdata", i), c0_rdata, tbl[i].erd);
        if (tbl[i].erv1) chk($sformatf("row%0d c1_rdata", i), c1_rdata, tbl[i].erd);
      end
    end

    // Overflow: three c1 pushes with the peripheral stalled; the third is dropped.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); drive_req(1, 1, 32'h5000 + 32'(4 * i)); mid();
    end
    begin_cycle(); mid();
    chk("ovf set", ovf, 2'b10);
    n_iss = 0;
    for (int i = 0; i < 12; i++) begin
      begin_cycle(); p_ack = 1; mid();
      if (p_req) begin
        if (n_iss < 4) iss[n_iss] = p_addr;
        n_iss++;
      end
    end
    chk("ovf issued count", n_iss, 2);
    chk("ovf issued 0", iss[0], 32'h5000);
    chk("ovf issued 1", iss[1], 32'h5004);
    chk("ovf sticky", ovf, 2'b10);

    // Full FIFO popped and pushed on the same edge keeps all three requests.
    do_reset();
    n_iss = 0;
    for (int i = 0; i < 15; i++) begin
      begin_cycle(); p_ack = 1;
      if (i < 3) drive_req(0, 1, 32'h8000 + 32'(4 * i));
      mid();
      if (p_req) begin
        if (n_iss < 4) iss[n_iss] = p_addr;
        n_iss++;
      end
    end
    chk("fullpp count", n_iss, 3);
    chk("fullpp 0", iss[0], 32'h8000);
    chk("fullpp 1", iss[1], 32'h8004);
    chk("fullpp 2", iss[2], 32'h8008);
    chk("fullpp ovf", ovf, 0);

    // p_rvalid on the timeout cycle wins and leaves tmo clear.
    do_reset();
    begin_cycle(); drive_req(0, 0, 32'h6100); mid();
    begin_cycle(); mid();
    begin_cycle(); p_ack = 1; mid();
    check_head("prio issue", 0, 32'h6100);
    quiet = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      begin_cycle(); mid();
      if (c0_rvalid || c1_rvalid || p_req || tmo) quiet++;
    end
    chk("prio quiet", quiet, 0);
    begin_cycle(); p_rvalid = 1; p_rdata = 32'h55; mid();
    begin_cycle(); mid();
    chk("prio c0_rvalid", c0_rvalid, 1);
    chk("prio c0_rdata", c0_rdata, 32'h55);
    chk("prio tmo", tmo, 0);
    begin_cycle(); mid();
    chk("prio pulse end", c0_rvalid, 0);

    // Timeout with a c1 write queued behind the stalled read.
    do_reset();
    begin_cycle(); drive_req(0, 0, 32'h6000); mid();
    begin_cycle(); drive_req(1, 1, 32'h7000); mid();
    begin_cycle(); p_ack = 1; mid();
    check_head("tmo issue", 0, 32'h6000);
    quiet = 0;
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      begin_cycle(); mid();
      if (c0_rvalid || c1_rvalid || p_req || tmo) quiet++;
    end
    chk("tmo quiet", quiet, 0);
    begin_cycle(); mid();
    chk("tmo c0_rvalid", c0_rvalid, 1);
    chk("tmo c0_rdata", c0_rdata, 32'hDEAD_BEEF);
    chk("tmo c1_rvalid", c1_rvalid, 0);
    chk("tmo flag", tmo, 1);
    begin_cycle(); p_ack = 1; mid();
    check_head("tmo next", 1, 32'h7000);
    begin_cycle(); mid();
    chk("tmo pulse end", c0_rvalid, 0);
    chk("tmo sticky", tmo, 1);

    // Reset while waiting for read data, with c1 overflowed and tmo still set.
    begin_cycle(); drive_req(0, 0, 32'h9000); mid();
    begin_cycle(); mid();
    begin_cycle(); p_ack = 1; mid();
    check_head("rstw issue", 0, 32'h9000);
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); drive_req(1, 1, 32'h9100 + 32'(4 * i)); mid();
    end
    begin_cycle(); rst = 1; mid();
    chk("rstw pre ovf", ovf, 2'b10);
    chk("rstw pre tmo", tmo, 1);
    begin_cycle(); p_rvalid = 1; p_rdata = 32'h77; mid();
    chk("rstw p_req", p_req, 0);
    chk("rstw ovf", ovf, 0);
    chk("rstw tmo", tmo, 0);
    chk("rstw c0_rdata", c0_rdata, 0);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      begin_cycle(); mid();
      if (c0_rvalid || c1_rvalid || p_req) quiet++;
    end
    chk("rstw quiet", quiet, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
